// File: rtl/ex_hilo_muldiv_pkg.sv
// ex_hilo_muldiv_pkg: shared state encoding, HI/LO select indices and operand helper for the EX mul/div unit
package ex_hilo_muldiv_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;
  localparam int HILO_SEL_LO = 0;
  localparam int HILO_SEL_HI = 1;
  function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/ex_hilo_muldiv_div_restoring32.sv
// div_restoring32: 32-step restoring divider on magnitudes with signed fix-up of quotient and remainder
module div_restoring32
  import ex_hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);
  logic        busy_q, busy_d, nq_q, nq_d, nr_q, nr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, rem_nx, quo_nx;
  logic [32:0] rem_sh, diff;
  // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as the dividend
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_nx = {quo_q[30:0], ~diff[32]};
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    nq_d   = nq_q;
    nr_d   = nr_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = 5'd0;
      rem_d  = 32'd0;
      quo_d  = abs_if(sgn, a);
      dvs_d  = abs_if(sgn, b);
      nq_d   = sgn && (a[31] ^ b[31]);
      nr_d   = sgn && a[31];
    end else if (busy_q) begin
      rem_d  = rem_nx;
      quo_d  = quo_nx;
      cnt_d  = cnt_q + 5'd1;
      busy_d = cnt_q != 5'd31;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= 5'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      nq_q   <= nq_d;
      nr_q   <= nr_d;
    end
  end
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == 5'd31);
  assign q    = nq_q ? -quo_nx : quo_nx;
  assign r    = nr_q ? -rem_nx : rem_nx;
endmodule

// File: rtl/ex_hilo_muldiv.sv
// ex_hilo_muldiv: EX-stage multiply/divide unit owning HI/LO; stalls while busy, commits when EX retires
module ex_hilo_muldiv
  import ex_hilo_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [1:0]  ex_hiloren,
  input  logic [1:0]  ex_hilowen,
  input  logic [31:0] ex_A,
  input  logic [31:0] ex_B,
  input  logic        ex_cancel,
  input  logic        refresh,
  input  logic        pipe_stall,
  output logic        md_stall,
  output logic [31:0] hilo_rdata
);
  md_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, res_hi_q, res_hi_d, res_lo_q, res_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic        mneg_q, mneg_d;
  logic        start, kill, leave, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [63:0] prod_abs, prod;
  assign start      = (ex_mult || ex_div) && !ex_cancel && !refresh;
  // A cancel seen mid-operation is handled exactly like a flush
  assign kill       = refresh || (ex_cancel && (state_q == ST_MUL || state_q == ST_DIV));
  assign md_stall   = !kill && ((state_q == ST_IDLE && start) || state_q == ST_MUL
                                || (state_q == ST_DIV && div_busy));
  assign leave      = !pipe_stall && !md_stall && !refresh;
  assign prod_abs   = {32'd0, ma_q} * {32'd0, mb_q};
  assign prod       = mneg_q ? -prod_abs : prod_abs;
  assign hilo_rdata = ex_hiloren[HILO_SEL_HI] ? hi_q : ex_hiloren[HILO_SEL_LO] ? lo_q : 32'd0;
  div_restoring32 u_div (
    .clk   (clk),
    .resetn(resetn),
    .start (state_q == ST_IDLE && start && ex_div),
    .abort (kill),
    .sgn   (ex_mdsign),
    .a     (ex_A),
    .b     (ex_B),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    mneg_d   = mneg_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_d   = 8'd0;
            ma_d    = abs_if(ex_mdsign, ex_A);
            mb_d    = abs_if(ex_mdsign, ex_B);
            mneg_d  = ex_mdsign && (ex_A[31] ^ ex_B[31]);
            state_d = ex_mult ? ST_MUL : ST_DIV;
          end else if (leave && !ex_cancel) begin
            hi_d = ex_hilowen[HILO_SEL_HI] ? ex_A : hi_q;
            lo_d = ex_hilowen[HILO_SEL_LO] ? ex_A : lo_q;
          end
        end
        ST_MUL: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(MUL_CYCLES - 1)) begin
            {res_hi_d, res_lo_d} = prod;
            state_d              = ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            res_hi_d = div_r;
            res_lo_d = div_q;
            state_d  = ST_DONE;
          end
        end
        default: begin
          if (leave) begin
            hi_d    = ex_cancel ? hi_q : res_hi_q;
            lo_d    = ex_cancel ? lo_q : res_lo_q;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      mneg_q   <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      mneg_q   <= mneg_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// tb_ex_hilo_muldiv: directed checks of MULT/DIV latency, results, flush, DONE hold and MTHI/MTLO
module tb_ex_hilo_muldiv;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        ex_mult = 1'b0, ex_div = 1'b0, ex_mdsign = 1'b0, ex_cancel = 1'b0, refresh = 1'b0, pipe_stall = 1'b0;
  logic [1:0]  ex_hiloren = 2'b00, ex_hilowen = 2'b00;
  logic [31:0] ex_A = 32'd0, ex_B = 32'd0;
  logic        md_stall;
  logic [31:0] hilo_rdata;
  int          checks = 0, errors = 0;
  ex_hilo_muldiv #(.MUL_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .ex_mult(ex_mult), .ex_div(ex_div), .ex_mdsign(ex_mdsign),
    .ex_hiloren(ex_hiloren), .ex_hilowen(ex_hilowen), .ex_A(ex_A), .ex_B(ex_B),
    .ex_cancel(ex_cancel), .refresh(refresh), .pipe_stall(pipe_stall),
    .md_stall(md_stall), .hilo_rdata(hilo_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    ex_mult = 1'b0; ex_div = 1'b0; ex_mdsign = 1'b0; ex_cancel = 1'b0;
    ex_hilowen = 2'b00; ex_hiloren = 2'b00; refresh = 1'b0;
  endtask
  task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    @(posedge clk); #1 clear(); ex_hiloren = sel;
    @(negedge clk); chk(tag, hilo_rdata, exp);
  endtask
  task automatic issue(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1 clear();
    ex_mult = m; ex_div = d; ex_mdsign = s; ex_A = a; ex_B = b;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!md_stall) break;
      n++;
    end
  endtask
  task automatic op(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n;
    issue(m, d, s, a, b);
    wait_done(n);
    chk({tag, "_stall"}, n, exp_cyc);
    rd(2'b10, exp_hi, {tag, "_hi"});
    rd(2'b01, exp_lo, {tag, "_lo"});
  endtask
  initial begin
    int n;
    ex_hiloren = 2'b10;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_stall", md_stall, 0);
    chk("rst_hi", hilo_rdata, 0);
    rd(2'b01, 32'd0, "rst_lo");
    op(1, 0, 1, 32'hFFFFFFFE, 32'd3, 3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");
    op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    op(0, 1, 0, 32'd100, 32'd7, 33, 32'd2, 32'd14, "divu");
    op(0, 1, 1, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, "div_negb");
    op(0, 1, 1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_nega");
    op(0, 1, 0, 32'd5, 32'd0, 33, 32'd5, 32'hFFFFFFFF, "divu_zero");
    // Flush during DIV: IDLE cycle plus DIV cycles 0..9, then refresh on cycle 10
    issue(0, 1, 0, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    chk("pre_flush_stall", md_stall, 1);
    refresh = 1'b1;
    #1 chk("flush_stall", md_stall, 0);
    @(posedge clk); #1 clear();
    @(negedge clk); chk("post_flush_stall", md_stall, 0);
    rd(2'b10, 32'd5, "flush_hi");
    rd(2'b01, 32'hFFFFFFFF, "flush_lo");
    op(0, 1, 0, 32'd1000, 32'd3, 33, 32'd1, 32'd333, "reissue");
    // DONE held by pipe_stall, observing HI throughout
    issue(1, 0, 0, 32'h00010000, 32'h00010000);
    pipe_stall = 1'b1; ex_hiloren = 2'b10;
    wait_done(n);
    chk("hold_stall", n, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_md_stall", md_stall, 0);
      chk("hold_hi", hilo_rdata, 32'd1);
    end
    @(posedge clk); #1 pipe_stall = 1'b0;
    @(negedge clk); chk("release_hi_pre", hilo_rdata, 32'd1);
    chk("release_md_stall", md_stall, 0);
    @(posedge clk); #1 ex_mult = 1'b0;
    @(negedge clk); chk("release_hi", hilo_rdata, 32'd1);
    chk("release_no_restart", md_stall, 0);
    rd(2'b01, 32'd0, "release_lo");
    // MTLO then MFLO; MTHI cancelled leaves HI alone
    @(posedge clk); #1 clear(); ex_hilowen = 2'b01; ex_A = 32'h1234;
    rd(2'b01, 32'h1234, "mtlo");
    @(posedge clk); #1 clear(); ex_hilowen = 2'b10; ex_A = 32'hDEADBEEF; ex_cancel = 1'b1;
    rd(2'b10, 32'd1, "mthi_cancel");
    @(posedge clk); #1 clear(); ex_hilowen = 2'b10; ex_A = 32'hCAFE0001;
    rd(2'b10, 32'hCAFE0001, "mthi");
    rd(2'b00, 32'd0, "no_read");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
